// File: rtl/ysyx_22040386_mem_arbiter.sv
// Arbiter sharing one memory bus port between instruction fetch and the MEM stage.
// One transaction in flight; MEM has priority, a starvation guard lets IF through.
module ysyx_22040386_mem_arbiter #(
  parameter int ADDR_W       = 64,
  parameter int DATA_W       = 64,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              i_ARB_clk,
  input  logic              i_ARB_rst,
  input  logic              i_ARB_if_req,
  input  logic [ADDR_W-1:0] i_ARB_if_addr,
  output logic              o_ARB_if_ready,
  output logic              o_ARB_if_rvalid,
  output logic [DATA_W-1:0] o_ARB_if_rdata,
  output logic              o_ARB_if_err,
  input  logic              i_ARB_mem_req,
  input  logic              i_ARB_mem_wen,
  input  logic [ADDR_W-1:0] i_ARB_mem_addr,
  input  logic [DATA_W-1:0] i_ARB_mem_wdata,
  input  logic [7:0]        i_ARB_mem_wmask,
  output logic              o_ARB_mem_ready,
  output logic              o_ARB_mem_rvalid,
  output logic [DATA_W-1:0] o_ARB_mem_rdata,
  output logic              o_ARB_mem_err,
  input  logic              i_ARB_flush,
  output logic              o_ARB_bus_req,
  output logic              o_ARB_bus_wen,
  output logic [ADDR_W-1:0] o_ARB_bus_addr,
  output logic [DATA_W-1:0] o_ARB_bus_wdata,
  output logic [7:0]        o_ARB_bus_wmask,
  input  logic              i_ARB_bus_gnt,
  input  logic              i_ARB_bus_rvalid,
  input  logic [DATA_W-1:0] i_ARB_bus_rdata,
  output logic [1:0]        o_ARB_dbg_state
);

  // Handshakes: a requester holds req+payload until its 1-cycle ready pulse
  // (combinational, IDLE only); the response is a 1-cycle rvalid pulse with
  // rdata/err, which hold their value between pulses.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [7:0]    TO_LAST    = 8'(TIMEOUT - 1);

  state_t      state, state_next;
  logic [SW-1:0] starve_cnt;
  logic [7:0]  to_cnt;
  logic        owner_mem;
  logic        drop;

  logic grant_if, grant_mem;
  logic busy, timed_out, bus_done, drop_now;

  assign busy      = (state == S_REQ) || (state == S_WAIT);
  // Fires in the TIMEOUT-th cycle spent in REQ/WAIT; the error pulse follows.
  assign timed_out = busy && (to_cnt == TO_LAST);
  assign bus_done  = (state == S_WAIT) && i_ARB_bus_rvalid;
  assign drop_now  = drop || (i_ARB_flush && !owner_mem);

  assign o_ARB_if_ready  = grant_if;
  assign o_ARB_mem_ready = grant_mem;
  assign o_ARB_dbg_state = state;

  always_comb begin
    grant_if  = 1'b0;
    grant_mem = 1'b0;
    if (state == S_IDLE && !i_ARB_rst) begin
      if (starve_cnt == STARVE_MAX && i_ARB_if_req) grant_if = 1'b1;
      else if (i_ARB_mem_req)                       grant_mem = 1'b1;
      else if (i_ARB_if_req && !i_ARB_flush)        grant_if = 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE: if (grant_if || grant_mem) state_next = S_REQ;
      S_REQ: begin
        if (timed_out)          state_next = S_IDLE;
        else if (i_ARB_bus_gnt) state_next = S_WAIT;
      end
      S_WAIT: if (bus_done || timed_out) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_ARB_clk) begin
    if (i_ARB_rst) begin
      state            <= S_IDLE;
      starve_cnt       <= '0;
      to_cnt           <= '0;
      owner_mem        <= 1'b1;
      drop             <= 1'b0;
      o_ARB_if_rvalid  <= 1'b0;
      o_ARB_if_rdata   <= '0;
      o_ARB_if_err     <= 1'b0;
      o_ARB_mem_rvalid <= 1'b0;
      o_ARB_mem_rdata  <= '0;
      o_ARB_mem_err    <= 1'b0;
      o_ARB_bus_req    <= 1'b0;
      o_ARB_bus_wen    <= 1'b0;
      o_ARB_bus_addr   <= '0;
      o_ARB_bus_wdata  <= '0;
      o_ARB_bus_wmask  <= '0;
    end else begin
      state            <= state_next;
      o_ARB_if_rvalid  <= 1'b0;
      o_ARB_mem_rvalid <= 1'b0;
      if (state == S_IDLE) begin
        if (grant_if || !i_ARB_if_req)             starve_cnt <= '0;
        else if (grant_mem && starve_cnt != STARVE_MAX) starve_cnt <= starve_cnt + SW'(1);
        if (grant_mem) begin
          owner_mem       <= 1'b1;
          o_ARB_bus_req   <= 1'b1;
          o_ARB_bus_wen   <= i_ARB_mem_wen;
          o_ARB_bus_addr  <= i_ARB_mem_addr;
          o_ARB_bus_wdata <= i_ARB_mem_wdata;
          o_ARB_bus_wmask <= i_ARB_mem_wmask;
          to_cnt          <= '0;
        end else if (grant_if) begin
          owner_mem       <= 1'b0;
          o_ARB_bus_req   <= 1'b1;
          o_ARB_bus_wen   <= 1'b0;
          o_ARB_bus_addr  <= i_ARB_if_addr;
          o_ARB_bus_wdata <= '0;
          o_ARB_bus_wmask <= '0;
          to_cnt          <= '0;
        end
      end else if (busy) begin
        to_cnt <= to_cnt + 8'd1;
        if (i_ARB_flush && !owner_mem) drop <= 1'b1;
        if (bus_done || timed_out) begin
          o_ARB_bus_req <= 1'b0;
          drop          <= 1'b0;
          if (owner_mem) begin
            o_ARB_mem_rvalid <= 1'b1;
            o_ARB_mem_err    <= !bus_done;
            if (!bus_done)          o_ARB_mem_rdata <= '1;
            else if (o_ARB_bus_wen) o_ARB_mem_rdata <= '0;
            else                    o_ARB_mem_rdata <= i_ARB_bus_rdata;
          end else if (!drop_now) begin
            // A flushed fetch still drains the bus but reports nothing.
            o_ARB_if_rvalid <= 1'b1;
            o_ARB_if_err    <= !bus_done;
            o_ARB_if_rdata  <= bus_done ? i_ARB_bus_rdata : '1;
          end
        end else if (state == S_REQ && i_ARB_bus_gnt) begin
          o_ARB_bus_req <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ysyx_22040386_mem_arbiter.sv
// Directed bench for ysyx_22040386_mem_arbiter: one task per scenario, inline checks,
// cycle numbering relative to the cycle in which the request is accepted (cycle 0).
module tb_ysyx_22040386_mem_arbiter;

  localparam int AW = 64;
  localparam int DW = 64;

  logic          clk;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ready, if_rvalid, if_err;
  logic [DW-1:0] if_rdata;
  logic          mem_req, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [7:0]    mem_wmask;
  logic          mem_ready, mem_rvalid, mem_err;
  logic [DW-1:0] mem_rdata;
  logic          flush;
  logic          bus_req, bus_wen;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic [7:0]    bus_wmask;
  logic          bus_gnt, bus_rvalid;
  logic [DW-1:0] bus_rdata;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [0:0] exp_q[$];

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [DW-1:0] ONES = '1;

  ysyx_22040386_mem_arbiter dut (
    .i_ARB_clk        (clk),
    .i_ARB_rst        (rst),
    .i_ARB_if_req     (if_req),
    .i_ARB_if_addr    (if_addr),
    .o_ARB_if_ready   (if_ready),
    .o_ARB_if_rvalid  (if_rvalid),
    .o_ARB_if_rdata   (if_rdata),
    .o_ARB_if_err     (if_err),
    .i_ARB_mem_req    (mem_req),
    .i_ARB_mem_wen    (mem_wen),
    .i_ARB_mem_addr   (mem_addr),
    .i_ARB_mem_wdata  (mem_wdata),
    .i_ARB_mem_wmask  (mem_wmask),
    .o_ARB_mem_ready  (mem_ready),
    .o_ARB_mem_rvalid (mem_rvalid),
    .o_ARB_mem_rdata  (mem_rdata),
    .o_ARB_mem_err    (mem_err),
    .i_ARB_flush      (flush),
    .o_ARB_bus_req    (bus_req),
    .o_ARB_bus_wen    (bus_wen),
    .o_ARB_bus_addr   (bus_addr),
    .o_ARB_bus_wdata  (bus_wdata),
    .o_ARB_bus_wmask  (bus_wmask),
    .i_ARB_bus_gnt    (bus_gnt),
    .i_ARB_bus_rvalid (bus_rvalid),
    .i_ARB_bus_rdata  (bus_rdata),
    .o_ARB_dbg_state  (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic clear_inputs();
    if_req     = 1'b0;
    if_addr    = '0;
    mem_req    = 1'b0;
    mem_wen    = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_wmask  = '0;
    flush      = 1'b0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = '0;
  endtask

  // Inputs change just after the falling edge; outputs are read 1 time unit later.
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    repeat (3) step();
    if_req = 1'b1; mem_req = 1'b1;
    settle();
    n_checks++;
    if ((if_ready | mem_ready) !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: if_ready=%b mem_ready=%b, required 0 0", if_ready, mem_ready);
    end
    n_checks++;
    if ((|{if_rvalid, if_rdata, if_err, mem_rvalid, mem_rdata, mem_err, bus_req, bus_wen,
           bus_addr, bus_wdata, bus_wmask, dbg_state}) !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: some output nonzero (bus_req=%b state=%0d), required all 0",
               bus_req, dbg_state);
    end
    step();
    rst = 1'b0; if_req = 1'b0; mem_req = 1'b0;
    step();
  endtask

  task automatic test_if_read();
    // cycle 0
    step();
    if_req = 1'b1; if_addr = 64'h8000_0000;
    settle();
    n_checks++;
    if ({if_ready, mem_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL if_read_ready: if_ready=%b mem_ready=%b, required 1 0", if_ready, mem_ready);
    end
    // cycle 1
    step();
    if_req = 1'b0; bus_gnt = 1'b1;
    settle();
    n_checks++;
    if ({bus_req, bus_wen, bus_wmask, bus_addr} !== {1'b1, 1'b0, 8'h00, 64'h8000_0000}) begin
      n_fail++;
      $display("FAIL if_read_bus: req=%b wen=%b wmask=%h addr=%h, required 1 0 00 80000000",
               bus_req, bus_wen, bus_wmask, bus_addr);
    end
    // cycle 2
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h13;
    settle();
    n_checks++;
    if ({bus_req, if_rvalid} !== 2'b00) begin
      n_fail++;
      $display("FAIL if_read_wait: bus_req=%b if_rvalid=%b, required 0 0", bus_req, if_rvalid);
    end
    // cycle 3
    step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    settle();
    n_checks++;
    if ({if_rvalid, if_err, if_rdata, mem_rvalid} !== {1'b1, 1'b0, 64'h13, 1'b0}) begin
      n_fail++;
      $display("FAIL if_read_resp: rvalid=%b err=%b rdata=%h mem_rvalid=%b, required 1 0 13 0",
               if_rvalid, if_err, if_rdata, mem_rvalid);
    end
    // cycle 4: pulse ends, data holds
    step();
    settle();
    n_checks++;
    if ({if_rvalid, if_rdata} !== {1'b0, 64'h13}) begin
      n_fail++;
      $display("FAIL if_read_hold: rvalid=%b rdata=%h, required 0 13", if_rvalid, if_rdata);
    end
  endtask

  task automatic test_mem_write();
    step();
    mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 64'h8000_1000;
    mem_wdata = 64'hDEAD_BEEF; mem_wmask = 8'h0F;
    settle();
    n_checks++;
    if ({mem_ready, if_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL mem_wr_ready: mem_ready=%b if_ready=%b, required 1 0", mem_ready, if_ready);
    end
    step();
    mem_req = 1'b0; mem_wen = 1'b0; mem_wdata = '0; mem_wmask = '0; bus_gnt = 1'b1;
    settle();
    n_checks++;
    if ({bus_req, bus_wen, bus_wmask, bus_addr, bus_wdata} !==
        {1'b1, 1'b1, 8'h0F, 64'h8000_1000, 64'hDEAD_BEEF}) begin
      n_fail++;
      $display("FAIL mem_wr_bus: req=%b wen=%b wmask=%h addr=%h wdata=%h, required 1 1 0f 80001000 deadbeef",
               bus_req, bus_wen, bus_wmask, bus_addr, bus_wdata);
    end
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h5555_AAAA;
    step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    settle();
    n_checks++;
    if ({mem_rvalid, mem_err, mem_rdata, if_rvalid} !== {1'b1, 1'b0, 64'h0, 1'b0}) begin
      n_fail++;
      $display("FAIL mem_wr_ack: rvalid=%b err=%b rdata=%h if_rvalid=%b, required 1 0 0 0",
               mem_rvalid, mem_err, mem_rdata, if_rvalid);
    end
  endtask

  task automatic test_starvation();
    int  n_grants;
    int  k;
    logic [0:0] exp_g;
    exp_q.delete();
    for (int r = 0; r < 2; r++) begin
      repeat (4) exp_q.push_back(1'b1);
      exp_q.push_back(1'b0);
    end
    n_grants = 0;
    step();
    if_req = 1'b1; if_addr = 64'h8000_0100;
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 64'h8000_2000;
    bus_gnt = 1'b1; bus_rvalid = 1'b1; bus_rdata = 64'h1234;
    k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      if (k != 0) step();
      settle();
      if (if_ready && mem_ready) begin
        n_checks++;
        n_fail++;
        $display("FAIL starve_both: if_ready and mem_ready both 1, required at most one");
      end else if (if_ready || mem_ready) begin
        exp_g = exp_q.pop_front();
        n_checks++;
        if (mem_ready !== exp_g) begin
          n_fail++;
          $display("FAIL starve_order: grant %0d went to %s, required %s", n_grants,
                   mem_ready ? "MEM" : "IF", exp_g ? "MEM" : "IF");
        end
        n_grants++;
      end
      k++;
    end
    n_checks++;
    if (n_grants != 10) begin
      n_fail++;
      $display("FAIL starve_count: %0d grants seen within budget, required 10", n_grants);
    end
    step();
    if_req = 1'b0; mem_req = 1'b0;
    repeat (4) step();
    clear_inputs();
    step();
  endtask

  task automatic test_timeout();
    int got;
    got = -1;
    step();
    if_req = 1'b1; if_addr = 64'h8000_0040;
    settle();
    n_checks++;
    if (if_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL to_ready: if_ready=%b, required 1", if_ready);
    end
    step();
    if_req = 1'b0;
    for (int k = 1; k <= 400; k++) begin
      if (k != 1) step();
      settle();
      if (k == 255) begin
        n_checks++;
        if (bus_req !== 1'b1) begin
          n_fail++;
          $display("FAIL to_req_held: bus_req=%b at cycle 255, required 1", bus_req);
        end
      end
      if (if_rvalid === 1'b1) begin
        got = k;
        break;
      end
    end
    n_checks++;
    if (got != 256) begin
      n_fail++;
      $display("FAIL to_cycle: if_rvalid at cycle %0d, required 256", got);
    end
    n_checks++;
    if ({if_err, if_rdata, bus_req, dbg_state} !== {1'b1, ONES, 1'b0, ST_IDLE}) begin
      n_fail++;
      $display("FAIL to_resp: err=%b rdata=%h bus_req=%b state=%0d, required 1 ffffffffffffffff 0 0",
               if_err, if_rdata, bus_req, dbg_state);
    end
    step();
    bus_rvalid = 1'b1; bus_rdata = 64'h99;
    step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    settle();
    n_checks++;
    if ({if_rvalid, mem_rvalid, if_rdata, dbg_state} !== {1'b0, 1'b0, ONES, ST_IDLE}) begin
      n_fail++;
      $display("FAIL to_late_rvalid: if_rvalid=%b mem_rvalid=%b rdata=%h state=%0d, required 0 0 all-ones 0",
               if_rvalid, mem_rvalid, if_rdata, dbg_state);
    end
  endtask

  task automatic test_flush();
    step();
    if_req = 1'b1; if_addr = 64'h8000_0200;
    step();
    if_req = 1'b0; bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0;
    settle();
    n_checks++;
    if ({dbg_state, if_rvalid} !== {ST_WAIT, 1'b0}) begin
      n_fail++;
      $display("FAIL flush_wait: state=%0d if_rvalid=%b, required 2 0", dbg_state, if_rvalid);
    end
    step();
    bus_rvalid = 1'b1; bus_rdata = 64'hABCD;
    step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 64'h8000_3000;
    settle();
    n_checks++;
    if ({if_rvalid, if_rdata, dbg_state} !== {1'b0, ONES, ST_IDLE}) begin
      n_fail++;
      $display("FAIL flush_drop: if_rvalid=%b rdata=%h state=%0d, required 0 all-ones 0",
               if_rvalid, if_rdata, dbg_state);
    end
    n_checks++;
    if (mem_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_mem_ready: mem_ready=%b, required 1", mem_ready);
    end
    step();
    mem_req = 1'b0; bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h77;
    step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    settle();
    n_checks++;
    if ({mem_rvalid, mem_err, mem_rdata} !== {1'b1, 1'b0, 64'h77}) begin
      n_fail++;
      $display("FAIL flush_mem_resp: rvalid=%b err=%b rdata=%h, required 1 0 77",
               mem_rvalid, mem_err, mem_rdata);
    end
    // flush landing on the response pulse must not hide it
    step();
    if_req = 1'b1; if_addr = 64'h8000_0300;
    step();
    if_req = 1'b0; bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h4242;
    step();
    bus_rvalid = 1'b0; bus_rdata = '0; flush = 1'b1;
    settle();
    n_checks++;
    if ({if_rvalid, if_rdata} !== {1'b1, 64'h4242}) begin
      n_fail++;
      $display("FAIL flush_on_pulse: rvalid=%b rdata=%h, required 1 4242", if_rvalid, if_rdata);
    end
    step();
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    step();
    mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 64'h8000_4000;
    step();
    mem_req = 1'b0; bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h66;
    settle();
    n_checks++;
    if ((|{if_ready, if_rvalid, if_rdata, if_err, mem_ready, mem_rvalid, mem_rdata, mem_err,
           bus_req, bus_wen, bus_addr, bus_wdata, bus_wmask, dbg_state}) !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_outputs: some output nonzero (bus_req=%b state=%0d), required all 0",
               bus_req, dbg_state);
    end
    step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    if_req = 1'b1; if_addr = 64'h8000_0500;
    settle();
    n_checks++;
    if ({mem_rvalid, if_rvalid, mem_rdata, if_ready} !== {1'b0, 1'b0, 64'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL rstmid_ignore: mem_rvalid=%b if_rvalid=%b mem_rdata=%h if_ready=%b, required 0 0 0 1",
               mem_rvalid, if_rvalid, mem_rdata, if_ready);
    end
    step();
    if_req = 1'b0; bus_gnt = 1'b1;
    step();
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_rdata = 64'h88;
    step();
    bus_rvalid = 1'b0; bus_rdata = '0;
    settle();
    n_checks++;
    if ({if_rvalid, if_err, if_rdata} !== {1'b1, 1'b0, 64'h88}) begin
      n_fail++;
      $display("FAIL rstmid_next: rvalid=%b err=%b rdata=%h, required 1 0 88",
               if_rvalid, if_err, if_rdata);
    end
  endtask

  // final report
  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_if_read();
    test_mem_write();
    test_starvation();
    test_timeout();
    test_flush();
    test_reset_mid();
    repeat (2) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
